output_diff_checker: RTL
========================

Name: output_diff_checker

Overview:
- Downstream consumer of the fuzz DUT output bus `y`. It is the synthesizable stage that judges one fuzz run.
- Two `top` instances (golden RTL and synthesized netlist) are driven with identical stimulus. Their `y` buses enter this block every sampled clock.
- The block counts and locates mismatches. It also compacts each stream into a MISR signature.
- At the end of a run of `n_cycles` samples it reports pass/fail. This replaces per-cycle `$strobe` text diffing.

Parameters:
- WIDTH, 481, width of each observed output bus (matches `y` of `top`).
- CNT_W, 16, width of the sample index, the length and the mismatch counter.
- MISR_W, 32, signature width.
- POLY, 32'h04C11DB7, Galois feedback polynomial.
- SEED, 32'hFFFFFFFF, signature value loaded at start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; arms a run (accepted only in IDLE or DONE).
- n_cycles  in  CNT_W  number of samples in the run; captured on the accepted start.
- sample_valid  in  1  y_ref and y_dut are valid this cycle.
- y_ref  in  WIDTH  golden instance output.
- y_dut  in  WIDTH  instance-under-test output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next accepted start.
- pass  out  1  valid when done; 1 iff mismatch_cnt==0 and sig_ref==sig_dut.
- mismatch_cnt  out  CNT_W  number of mismatching samples; saturates at all-ones.
- first_mm_valid  out  1  a mismatch has been recorded this run.
- first_mm_idx  out  CNT_W  sample index of the first mismatch.
- sig_ref  out  MISR_W  running signature of y_ref.
- sig_dut  out  MISR_W  running signature of y_dut.

Behaviour:
- Reset (async on rst_n low, takes effect immediately):
  - state=IDLE.
  - busy=0, done=0, pass=0.
  - mismatch_cnt=0, first_mm_valid=0, first_mm_idx=0.
  - sig_ref=sig_dut=SEED, internal sample_idx=0.
- Reset mid-run aborts the run. No partial result is retained.
- States:
  - IDLE: start -> RUN if n_cycles!=0, else -> DONE with pass=1 and signatures at SEED.
  - RUN: on each cycle with sample_valid=1:
    - mismatch = |(y_ref ^ y_dut), a 2-state compare.
    - If mismatch, mismatch_cnt increments (saturating). If first_mm_valid=0, capture first_mm_idx=sample_idx and set first_mm_valid=1.
    - Both signatures update.
    - sample_idx increments. If sample_idx==n_cycles-1 the state goes -> DONE on the same edge.
  - RUN with sample_valid=0: everything holds.
  - DONE: done=1; pass registered on entry. A new start clears results, reloads SEED and n_cycles, and -> RUN (or -> DONE for n_cycles=0). done drops on that edge.
- start while in RUN is ignored. A start coincident with the final sample is also ignored.
- Result latency: done, pass and final counters are visible the cycle after the last sample edge, i.e. registered outputs, no combinational path from inputs.
- Signature update, identical for both streams:
  - fold(y) = XOR of the 16 MISR_W-bit slices of y. The top slice is zero-padded (481 = 15*32+1).
  - sig_next = {sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? POLY : 0) ^ fold(y).
- X/Z on inputs are not interpreted (the synthesizable compare is 2-state); X detection belongs to the bench.

Decomposition:
- Shared package `diff_check_pkg` holds:
  - state enum {IDLE, RUN, DONE};
  - default POLY and SEED constants;
  - fold slice count localparam computed as (WIDTH+MISR_W-1)/MISR_W.
- One sub-module, `misr_fold` (params WIDTH, MISR_W, POLY, SEED; ports clk, rst_n, clear, en, din, sig), instantiated twice.
- The FSM, counters and compare stay in the top module.

Test Plan:
- Reset with rst_n=0 mid-RUN -> busy=0, done=0, mismatch_cnt=0, sig_ref=sig_dut=32'hFFFFFFFF asynchronously, before the next clk edge.
- start, n_cycles=1, y_ref=y_dut=0, sample_valid=1 -> next cycle done=1, pass=1, sig_ref=sig_dut=32'hFB3EE249.
- start, n_cycles=4, y_ref=y_dut except y_dut[0] flipped on sample 2 -> done=1, pass=0, mismatch_cnt=1, first_mm_valid=1, first_mm_idx=2, sig_ref!=sig_dut.
- start, n_cycles=3, sample_valid pattern 1,0,0,1,1 with equal data -> done asserts only after the 5th cycle; busy=1 for exactly 5 cycles.
- start, n_cycles=0 -> DONE next cycle, pass=1, mismatch_cnt=0, signatures 32'hFFFFFFFF.
- start pulsed again during RUN (n_cycles=4) -> ignored, run completes after 4 samples; then start from DONE -> counters cleared, done=0, busy=1.

Source files
------------

// File: rtl/diff_check_pkg.sv
// Shared types and constants for the output diff checker and its MISR.
package diff_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  localparam int DEF_WIDTH   = 481;
  localparam int DEF_MISR_W  = 32;
  localparam int FOLD_SLICES = (DEF_WIDTH + DEF_MISR_W - 1) / DEF_MISR_W;

  // Number of MISR_W-wide slices needed to cover a WIDTH-bit bus.
  function automatic int fold_slices(input int width, input int misr_w);
    return (width + misr_w - 1) / misr_w;
  endfunction

endpackage

// File: rtl/misr_fold.sv
// Galois MISR that compacts one wide output bus per enabled cycle.
// The bus is folded to MISR_W bits by XOR-ing its slices (top slice zero-padded).
module misr_fold
  import diff_check_pkg::*;
#(
  parameter int                WIDTH  = 481,
  parameter int                MISR_W = 32,
  parameter logic [MISR_W-1:0] POLY   = DEF_POLY,
  parameter logic [MISR_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  output logic [MISR_W-1:0] sig
);

  localparam int SLICES = fold_slices(WIDTH, MISR_W);

  logic [SLICES*MISR_W-1:0] din_pad;
  logic [MISR_W-1:0]        fold;
  logic [MISR_W-1:0]        sig_d, sig_q;

  // Zero-pad the bus to a whole number of slices, then XOR the slices together.
  always_comb begin
    din_pad            = '0;
    din_pad[WIDTH-1:0] = din;
    fold               = '0;
    for (int k = 0; k < SLICES; k++) fold = fold ^ din_pad[k*MISR_W +: MISR_W];
  end

  // Next signature: clear reloads the seed, otherwise shift with feedback and fold in.
  always_comb begin
    sig_d = sig_q;
    if (clear)
      sig_d = SEED;
    else if (en)
      sig_d = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? POLY : '0) ^ fold;
  end

  // Signature register, seeded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/output_diff_checker.sv
// Judges one fuzz run: compares golden and under-test output buses sample by
// sample, counts and locates mismatches, and compacts both streams into MISRs.
// All outputs decode registered state only; nothing flows combinationally
// from the inputs to the outputs.
module output_diff_checker
  import diff_check_pkg::*;
#(
  parameter int                WIDTH  = 481,
  parameter int                CNT_W  = 16,
  parameter int                MISR_W = 32,
  parameter logic [MISR_W-1:0] POLY   = DEF_POLY,
  parameter logic [MISR_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_cycles,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  y_ref,
  input  logic [WIDTH-1:0]  y_dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              first_mm_valid,
  output logic [CNT_W-1:0]  first_mm_idx,
  output logic [MISR_W-1:0] sig_ref,
  output logic [MISR_W-1:0] sig_dut
);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] len_d, len_q;
  logic [CNT_W-1:0] idx_d, idx_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             fv_d, fv_q;
  logic [CNT_W-1:0] fidx_d, fidx_q;
  logic             sig_clear, sig_en;
  logic             mismatch;

  // 2-state compare of the two buses; X/Z handling is left to the bench.
  assign mismatch = |(y_ref ^ y_dut);

  // Run control, sample indexing and mismatch bookkeeping.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fv_d      = fv_q;
    fidx_d    = fidx_q;
    sig_clear = 1'b0;
    sig_en    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_clear = 1'b1;
          len_d     = n_cycles;
          idx_d     = '0;
          cnt_d     = '0;
          fv_d      = 1'b0;
          fidx_d    = '0;
          // A zero-length run finishes immediately with seed signatures.
          state_d   = (n_cycles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here, including on the last sample.
        if (sample_valid) begin
          sig_en = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (mismatch) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fidx_d = idx_q;
            end
          end
          if (idx_q == len_q - 1'b1) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and counter registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fidx_q  <= fidx_d;
    end
  end

  misr_fold #(
    .WIDTH (WIDTH),
    .MISR_W(MISR_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_ref (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(sig_clear),
    .en   (sig_en),
    .din  (y_ref),
    .sig  (sig_ref)
  );

  misr_fold #(
    .WIDTH (WIDTH),
    .MISR_W(MISR_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(sig_clear),
    .en   (sig_en),
    .din  (y_dut),
    .sig  (sig_dut)
  );

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  // Verdict is formed from the final registered counters and signatures,
  // so it is stable for as long as DONE is held.
  assign pass           = done && (cnt_q == '0) && (sig_ref == sig_dut);
  assign mismatch_cnt   = cnt_q;
  assign first_mm_valid = fv_q;
  assign first_mm_idx   = fidx_q;

endmodule
